// File: rtl/cuenta_unos_param_if.sv
// Start/fin handshake bundle for the parametrised population counter.
interface cuenta_unos_param_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
);
    logic          start;
    logic [N-1:0]  Valor;
    logic          modo;
    logic [CW-1:0] Cuenta;
    logic          fin;
    logic          ocupado;

    // Requester side: issues operands, observes the result.
    modport master (
        output start, Valor, modo,
        input  Cuenta, fin, ocupado
    );

    // Counter side: accepts operands, publishes the result.
    modport slave (
        input  start, Valor, modo,
        output Cuenta, fin, ocupado
    );
endinterface

// File: rtl/cuenta_unos_param.sv
// Sequential ones/zeros counter: shift register + accumulator under a
// three-state control unit, with early exit once no set bits remain.
module cuenta_unos_param #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    cuenta_unos_param_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CUENTA = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] a_q, a_d;
    logic [CW-1:0] cuenta_q, cuenta_d;
    logic          fin_q, fin_d;
    logic          ocupado_q, ocupado_d;

    // State, datapath and output registers; reset drops any partial result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= REPOSO;
            q_q       <= '0;
            a_q       <= '0;
            cuenta_q  <= '0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            a_q       <= a_d;
            cuenta_q  <= cuenta_d;
            fin_q     <= fin_d;
            ocupado_q <= ocupado_d;
        end
    end

    // Next state, datapath control and registered-output next values.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        a_d       = a_q;
        cuenta_d  = cuenta_q;
        fin_d     = 1'b0;
        ocupado_d = 1'b0;

        unique case (state_q)
            REPOSO: begin
                if (bus.start) begin
                    // Inverting before the load lets zero-counting reuse the early exit.
                    q_d     = bus.modo ? ~bus.Valor : bus.Valor;
                    a_d     = '0;
                    state_d = CUENTA;
                end
            end
            CUENTA: begin
                a_d = a_q + CW'(q_q[0]);
                q_d = q_q >> 1;
                if ((q_q >> 1) == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                cuenta_d = a_q;
                fin_d    = 1'b1;
                state_d  = REPOSO;
                if (bus.start) begin
                    q_d     = bus.modo ? ~bus.Valor : bus.Valor;
                    a_d     = '0;
                    state_d = CUENTA;
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase

        // Busy mirrors the state being entered so it aligns with CUENTA.
        ocupado_d = (state_d == CUENTA);
    end

    assign bus.Cuenta  = cuenta_q;
    assign bus.fin     = fin_q;
    assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_cuenta_unos_param.sv
// Directed bench for cuenta_unos_param: vector table plus hand-written
// back-to-back and reset-during-count sequences.
module tb_cuenta_unos_param;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = $clog2(N + 1);

    logic clk;
    logic reset;

    cuenta_unos_param_if #(.N(N), .CW(CW)) bus ();

    cuenta_unos_param #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valor;
        logic         modo;
        int           exp_cuenta;
        int           exp_cycles;
    } vec_t;

    vec_t vecs [10];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accept one operand, then watch ocupado/fin/Cuenta edge by edge.
    task automatic run_vec(input vec_t v, input int id);
        int fin_idx;
        int fin_cnt;
        int ocu_cnt;
        int cnt_at_fin;
        fin_idx    = -1;
        fin_cnt    = 0;
        ocu_cnt    = 0;
        cnt_at_fin = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Valor = v.valor;
        bus.modo  = v.modo;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k <= v.exp_cycles + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.fin) begin
                fin_cnt++;
                if (fin_idx < 0) begin
                    fin_idx    = k;
                    cnt_at_fin = int'(bus.Cuenta);
                end
            end
            if (bus.ocupado) ocu_cnt++;
            // Scramble operand inputs and poke start mid-count; none may matter.
            bus.Valor = N'($urandom);
            bus.modo  = 1'($urandom);
            if (k == 1 && v.exp_cycles >= 3) bus.start = 1'b1;
            if (k == 2) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check($sformatf("v%0d ocupado_cycles", id), ocu_cnt, v.exp_cycles);
        check($sformatf("v%0d fin_latency", id), fin_idx, v.exp_cycles + 1);
        check($sformatf("v%0d fin_pulses", id), fin_cnt, 1);
        check($sformatf("v%0d cuenta_at_fin", id), cnt_at_fin, v.exp_cuenta);
        check($sformatf("v%0d cuenta_held", id), int'(bus.Cuenta), v.exp_cuenta);
    endtask

    initial begin
        int ocu_s [18];
        int fin_s [18];
        int cnt_s [18];
        int tot_fin;
        int tot_ocu;
        vec_t v;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'b1011_0010, 1'b0, 4, 8};
        vecs[1] = '{8'b0000_0101, 1'b0, 2, 3};
        vecs[2] = '{8'b0000_0101, 1'b1, 6, 8};
        vecs[3] = '{8'h00,        1'b0, 0, 1};
        vecs[4] = '{8'hFF,        1'b0, 8, 8};
        vecs[5] = '{8'hFF,        1'b1, 0, 1};
        vecs[6] = '{8'h80,        1'b0, 1, 8};
        vecs[7] = '{8'h01,        1'b0, 1, 1};
        vecs[8] = '{8'h7F,        1'b1, 1, 8};
        vecs[9] = '{8'hF0,        1'b1, 4, 4};

        // Reset and idle.
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.Valor = '0;
        bus.modo  = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("reset cuenta", int'(bus.Cuenta), 0);
        check("reset fin", int'(bus.fin), 0);
        check("reset ocupado", int'(bus.ocupado), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle%0d cuenta", i), int'(bus.Cuenta), 0);
            check($sformatf("idle%0d fin", i), int'(bus.fin), 0);
            check($sformatf("idle%0d ocupado", i), int'(bus.ocupado), 0);
        end

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of counting 8'hFF; Cuenta currently holds 4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.Valor = 8'hFF;
        bus.modo  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre-reset ocupado", int'(bus.ocupado), 1);
        reset = 1'b0;
        #1;
        check("midreset cuenta", int'(bus.Cuenta), 0);
        check("midreset fin", int'(bus.fin), 0);
        check("midreset ocupado", int'(bus.ocupado), 0);
        @(negedge clk);
        reset   = 1'b1;
        tot_fin = 0;
        tot_ocu = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tot_fin += int'(bus.fin);
            tot_ocu += int'(bus.ocupado);
        end
        check("post-reset fin", tot_fin, 0);
        check("post-reset ocupado", tot_ocu, 0);
        v = '{8'h03, 1'b0, 2, 2};
        run_vec(v, 10);

        // Back-to-back: start held through FIN, operand swapped to 8'h0F.
        @(negedge clk);
        bus.start = 1'b1;
        bus.Valor = 8'h81;
        bus.modo  = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ocu_s[k] = int'(bus.ocupado);
            fin_s[k] = int'(bus.fin);
            cnt_s[k] = int'(bus.Cuenta);
            if (k == 1) bus.Valor = 8'h0F;
            if (k == 9) bus.start = 1'b0;
        end
        tot_fin = 0;
        tot_ocu = 0;
        for (int k = 0; k < 18; k++) begin
            tot_fin += fin_s[k];
            tot_ocu += ocu_s[k];
        end
        check("b2b gap ocupado", ocu_s[8], 0);
        check("b2b first fin", fin_s[9], 1);
        check("b2b first cuenta", cnt_s[9], 2);
        check("b2b restart ocupado", ocu_s[9], 1);
        check("b2b second idle", ocu_s[13], 0);
        check("b2b second fin", fin_s[14], 1);
        check("b2b second cuenta", cnt_s[14], 4);
        check("b2b fin total", tot_fin, 2);
        check("b2b ocupado total", tot_ocu, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cuenta_unos_param.md
Name: cuenta_unos_param

Overview:
- Sequential population counter, the parametrised successor of the 3-bit ones counter.
- Loads an N-bit operand into a shift register and shifts it right one bit per cycle. An accumulator adds each LSB. A control FSM sequences the operation.
- Adds a mode input (count ones or count zeros), early termination when no set bits remain, a busy flag, and a result register that holds its value between operations.
- Sits beside the other datapath+control-unit exercise blocks and is driven by a simple start/fin handshake.

Parameters:
- N, 8, operand width in bits (N >= 2).
- CW, $clog2(N+1), width of Cuenta; must hold the value N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a count; sampled on the rising edge.
- Valor  input  N  operand; sampled only in the cycle start is accepted.
- modo  input  1  0 = count ones; 1 = count zeros. Sampled together with Valor.
- Cuenta  output  CW  result register.
- fin  output  1  one-cycle pulse: Cuenta has just been updated.
- ocupado  output  1  high while a count is in progress.

Behaviour:
- Reset (reset=0, asynchronous assert): state=REPOSO, Q=0, A=0, Cuenta=0, fin=0, ocupado=0. Deassertion is synchronous to clk in the instantiating logic.
- Internal registers: Q[N-1:0] (shift register), A[CW-1:0] (accumulator).
- FSM states: REPOSO, CUENTA, FIN.
- REPOSO:
  - ocupado=0, fin=0.
  - If start=1: Q <= modo ? ~Valor : Valor; A <= 0; next state CUENTA.
  - Otherwise hold. Cuenta holds its last value.
- CUENTA:
  - ocupado=1.
  - Each cycle: A <= A + Q[0]; Q <= Q >> 1 (zero fill).
  - If (Q >> 1) == 0 in the current cycle, next state FIN. Otherwise stay.
  - start is ignored.
- FIN:
  - Cuenta <= A (the final sum, including the last bit added on the transition into FIN); fin=1 for exactly this cycle.
  - ocupado=0.
  - Next state REPOSO, unless start=1, in which case load as in REPOSO and go directly to CUENTA (back-to-back operation).
- Latency:
  - Let h = index of the highest set bit of the loaded Q, or h=0 if Q==0.
  - CUENTA lasts h+1 cycles (at least 1, at most N).
  - fin rises h+2 cycles after the edge that accepts start.
- Arithmetic: A never exceeds N, so there is no overflow in CW bits. Mode inversion is applied before loading Q, so the same early-exit rule applies in both modes.
- Boundaries:
  - Valor=0 with modo=0: a single CUENTA cycle, result 0.
  - Valor all ones with modo=1: same as above, result 0.
  - Valor all ones with modo=0: N CUENTA cycles, result N.
- Reset mid-operation: immediately returns to REPOSO with all registers cleared. A partial result is never published.
- Valor and modo changing after acceptance have no effect on the count in progress.

Test Plan:
- N=8, reset low then high, idle 3 cycles -> Cuenta=0, fin=0, ocupado=0 throughout.
- N=8, start with Valor=8'b1011_0010, modo=0 -> ocupado high 8 cycles; fin pulses 1 cycle at accept+9; Cuenta=4.
- N=8, Valor=8'b0000_0101, modo=0 -> 3 CUENTA cycles (early exit), fin at accept+4, Cuenta=2. Then the same Valor with modo=1 -> Cuenta=6 after 8 CUENTA cycles.
- N=8, Valor=0, modo=0 -> 1 CUENTA cycle, fin at accept+2, Cuenta=0. Valor=8'hFF, modo=0 -> Cuenta=8 (max value, no overflow).
- Back-to-back: start held high through FIN with Valor changed to 8'h0F -> next count begins without passing through REPOSO; second fin gives Cuenta=4. A start pulse asserted during CUENTA is ignored.
- Reset asserted mid-CUENTA of 8'hFF -> outputs are 0 asynchronously, no fin. A fresh start with 8'h03 afterwards -> Cuenta=2.
